// File: rtl/fast_vram_sched.sv
// fast_vram_sched: fixed four-slot scheduler for the 2Kx16 fast VRAM on CLK_24M.
//   Slots (2 cycles each): S0 render read, S1 Y-parse read, S2 active-list read,
//   S3 active-list write or CPU access. Owns parse index, active write/read
//   counters and the double-buffer bank bit.
// Ports:
//   CLK_24M, RESETP (sync, active high), NEW_LINE (line start pulse)
//   RENDER_ADDR, ACTIVE_RD_EN, PARSE_MATCH          - timing/compare inputs
//   CPU_REQ/CPU_WE/CPU_ADDR/CPU_WDATA -> CPU_ACK/CPU_RDATA  - CPU port
//   VRAM_A/VRAM_DOUT/VRAM_WE/VRAM_DIN                - fast VRAM pins
//   RENDER_VLD/PARSE_VLD/ACTIVE_RD_VLD               - read data strobes
//   PARSE_IDX, ACTIVE_RD, BANK, PARSE_DONE, ACTIVE_FULL - state/status
// Optional feature: define FASTSCHED_CPU_FAIRNESS_EN to let a CPU request
//   that lost S3 to an active-list write win the following S3.
module fast_vram_sched (
  input  logic        CLK_24M,
  input  logic        RESETP,
  input  logic        NEW_LINE,
  input  logic [10:0] RENDER_ADDR,
  input  logic        ACTIVE_RD_EN,
  input  logic        PARSE_MATCH,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [10:0] CPU_ADDR,
  input  logic [15:0] CPU_WDATA,
  output logic        CPU_ACK,
  output logic [15:0] CPU_RDATA,
  output logic [10:0] VRAM_A,
  output logic [15:0] VRAM_DOUT,
  input  logic [15:0] VRAM_DIN,
  output logic        VRAM_WE,
  output logic        RENDER_VLD,
  output logic        PARSE_VLD,
  output logic        ACTIVE_RD_VLD,
  output logic [8:0]  PARSE_IDX,
  output logic [6:0]  ACTIVE_RD,
  output logic        BANK,
  output logic        PARSE_DONE,
  output logic        ACTIVE_FULL
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_e;

  localparam logic [8:0] LAST_IDX = 9'd382;
  localparam logic [6:0] FULL_CNT = 7'd96;

  logic [2:0]  ph_q, ph_d;
  logic        bank_q, bank_d;
  logic [8:0]  idx_q, idx_d;
  logic [6:0]  wcnt_q, wcnt_d;
  logic [6:0]  ard_q, ard_d;
  logic        pend_q, pend_d;
  logic [8:0]  widx_q, widx_d;
  logic        done_q, done_d;
  gnt_e        gnt_q, gnt_d;
  logic [15:0] rdata_q, rdata_d;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
  logic        starve_q, starve_d;
`endif

  logic parse_ok;
  logic full;
  logic wr_win;
  logic ack;
  gnt_e gnt_sel;
  logic [1:0] slot;

  // S3 owner: decided combinationally during ph6, frozen in gnt_q for ph7.
  gnt_e s3_gnt;

  always_comb begin
    // pend and done only change at ph5/ph7, so this also tells ph5 whether
    // the S1 read of the current frame actually happened.
    parse_ok = !done_q && !pend_q;
    full     = (wcnt_q >= FULL_CNT);
`ifdef FASTSCHED_CPU_FAIRNESS_EN
    wr_win   = pend_q && !(starve_q && CPU_REQ);
`else
    wr_win   = pend_q;
`endif
    if (wr_win)       gnt_sel = GNT_WR;
    else if (CPU_REQ) gnt_sel = GNT_CPU;
    else              gnt_sel = GNT_IDLE;

    if (ph_q == 3'd6)      s3_gnt = gnt_sel;
    else if (ph_q == 3'd7) s3_gnt = gnt_q;
    else                   s3_gnt = GNT_IDLE;

    // A NEW_LINE landing on ph7 aborts the access before it completes.
    ack  = (ph_q == 3'd7) && (gnt_q == GNT_CPU) && !NEW_LINE;
    slot = ph_q[2:1];
  end

  // Bus outputs
  always_comb begin
    VRAM_A    = RENDER_ADDR;
    VRAM_DOUT = 16'h0000;
    VRAM_WE   = 1'b0;
    case (slot)
      2'd0: VRAM_A = RENDER_ADDR;
      2'd1: VRAM_A = {2'b01, idx_q};
      2'd2: VRAM_A = {3'b110, ~bank_q, ard_q};
      default: begin
        case (s3_gnt)
          GNT_WR: begin
            VRAM_A    = {3'b110, bank_q, wcnt_q};
            VRAM_DOUT = {7'b0, widx_q};
            VRAM_WE   = 1'b1;
          end
          GNT_CPU: begin
            VRAM_A    = CPU_ADDR;
            VRAM_DOUT = CPU_WE ? CPU_WDATA : 16'h0000;
            VRAM_WE   = CPU_WE;
          end
          default: VRAM_A = {2'b01, idx_q};
        endcase
      end
    endcase
  end

  assign RENDER_VLD    = (ph_q == 3'd1);
  assign PARSE_VLD     = (ph_q == 3'd3) && parse_ok;
  assign ACTIVE_RD_VLD = (ph_q == 3'd5);
  assign CPU_ACK       = ack;
  // Read data passes straight through during the ACK cycle, then is held.
  assign CPU_RDATA     = (ack && !CPU_WE) ? VRAM_DIN : rdata_q;
  assign PARSE_IDX     = idx_q;
  assign ACTIVE_RD     = ard_q;
  assign BANK          = bank_q;
  assign PARSE_DONE    = done_q;
  assign ACTIVE_FULL   = full;

  // Next state
  always_comb begin
    ph_d    = ph_q + 3'd1;
    bank_d  = bank_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    ard_d   = ard_q;
    pend_d  = pend_q;
    widx_d  = widx_q;
    done_d  = done_q;
    gnt_d   = gnt_q;
    rdata_d = rdata_q;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
    starve_d = starve_q;
`endif

    case (ph_q)
      3'd5: begin
        if (ACTIVE_RD_EN) ard_d = ard_q + 7'd1;
        // Matches while full are dropped; the index advances at ph7.
        if (parse_ok && PARSE_MATCH && !full) begin
          pend_d = 1'b1;
          widx_d = idx_q;
        end
      end
      3'd6: begin
        gnt_d = gnt_sel;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
        if (CPU_REQ && (gnt_sel == GNT_WR)) starve_d = 1'b1;
`endif
      end
      3'd7: begin
        gnt_d = GNT_IDLE;
        if (gnt_q == GNT_WR) begin
          wcnt_d = wcnt_q + 7'd1;
          pend_d = 1'b0;
          idx_d  = idx_q + 9'd1;
        end else if (parse_ok) begin
          idx_d  = idx_q + 9'd1;
        end
        if (gnt_q == GNT_CPU) begin
          if (!CPU_WE) rdata_d = VRAM_DIN;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
          starve_d = 1'b0;
`endif
        end
      end
      default: ;
    endcase

    if (idx_d == LAST_IDX) done_d = 1'b1;

    // Line start overrides everything above, including a ph7 completion.
    if (NEW_LINE) begin
      ph_d    = 3'd0;
      bank_d  = ~bank_q;
      idx_d   = 9'd0;
      wcnt_d  = 7'd0;
      ard_d   = 7'd0;
      pend_d  = 1'b0;
      widx_d  = widx_q;
      done_d  = 1'b0;
      gnt_d   = GNT_IDLE;
      rdata_d = rdata_q;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
      starve_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      ph_q    <= 3'd0;
      bank_q  <= 1'b0;
      idx_q   <= 9'd0;
      wcnt_q  <= 7'd0;
      ard_q   <= 7'd0;
      pend_q  <= 1'b0;
      widx_q  <= 9'd0;
      done_q  <= 1'b0;
      gnt_q   <= GNT_IDLE;
      rdata_q <= 16'h0000;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
      starve_q <= 1'b0;
`endif
    end else begin
      ph_q    <= ph_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      wcnt_q  <= wcnt_d;
      ard_q   <= ard_d;
      pend_q  <= pend_d;
      widx_q  <= widx_d;
      done_q  <= done_d;
      gnt_q   <= gnt_d;
      rdata_q <= rdata_d;
`ifdef FASTSCHED_CPU_FAIRNESS_EN
      starve_q <= starve_d;
`endif
    end
  end

endmodule
